// File: rtl/dm_access_unit.sv
// MEM-stage load/store unit in front of a 4 KiB word memory; sub-word stores run as read-modify-write.
// Optional build macro DM_ACCESS_MISALIGN_TRAP_EN: reject misaligned H/W accesses with an addr_err pulse.
module dm_access_unit #(
  parameter int BIG_ENDIAN = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_req_op,
  input  logic [11:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic [31:0] o_rdata,
  output logic        o_rdata_vld,
  output logic        o_addr_err,
  output logic [9:0]  o_dm_addr,
  output logic [31:0] o_dm_din,
  output logic        o_dm_we,
  input  logic [31:0] i_dm_dout
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_RMW_WR = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_rdata;
  logic        r_rdata_vld;
  logic [31:0] r_merge;
  logic [9:0]  r_addr;

  logic        w_store;
  logic        w_uns;
  logic [1:0]  w_size;
  logic        w_idle;
  logic        w_accept;
  logic        w_illegal;
  logic        w_misal;
  logic        w_do;
  logic        w_load;
  logic        w_sw;
  logic        w_sub;

  function automatic logic [1:0] f_byte_lane(input logic [1:0] a);
    if (BIG_ENDIAN != 0) begin
      f_byte_lane = 2'd3 - a;
    end else begin
      f_byte_lane = a;
    end
  endfunction

  function automatic logic f_half_lane(input logic a1);
    if (BIG_ENDIAN != 0) begin
      f_half_lane = ~a1;
    end else begin
      f_half_lane = a1;
    end
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] size,
                                         input logic uns, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{f_byte_lane(a), 3'b000} +: 8];
    h = word[{f_half_lane(a[1]), 4'b0000} +: 16];
    case (size)
      SZ_B:    f_load = {{24{b[7] & ~uns}}, b};
      SZ_H:    f_load = {{16{h[15] & ~uns}}, h};
      default: f_load = word;
    endcase
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [1:0] size,
                                          input logic [31:0] wdata, input logic [1:0] a);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_B:    res[{f_byte_lane(a), 3'b000} +: 8] = wdata[7:0];
      SZ_H:    res[{f_half_lane(a[1]), 4'b0000} +: 16] = wdata[15:0];
      default: res = wdata;
    endcase
    f_merge = res;
  endfunction

  // Request decode; illegal and (optionally) misaligned requests are accepted but do nothing.
  always_comb begin
    w_store   = i_req_op[3];
    w_uns     = i_req_op[2];
    w_size    = i_req_op[1:0];
    w_idle    = (r_state == S_IDLE);
    w_accept  = i_req_valid & w_idle;
    w_illegal = (w_size == 2'b11) | (w_store & w_uns);
`ifdef DM_ACCESS_MISALIGN_TRAP_EN
    w_misal   = ((w_size == SZ_H) & i_req_addr[0]) |
                ((w_size == SZ_W) & (i_req_addr[1:0] != 2'b00));
`else
    w_misal   = 1'b0;
`endif
    w_do      = w_accept & ~w_illegal & ~w_misal & ~i_rst;
    w_load    = w_do & ~w_store;
    w_sw      = w_do & w_store & (w_size == SZ_W);
    w_sub     = w_do & w_store & (w_size != SZ_W);
  end

  // Next state and memory-side outputs; a reset cycle never writes.
  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = 1'b0;
    o_dm_addr   = i_req_addr[11:2];
    o_dm_din    = i_req_wdata;
    o_dm_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        o_dm_we     = w_sw;
        if (w_sub) begin
          w_state_nxt = S_RMW_WR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RMW_WR: begin
        o_dm_addr   = r_addr;
        o_dm_din    = r_merge;
        o_dm_we     = ~i_rst;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, load result and merge word registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rdata     <= 32'd0;
      r_rdata_vld <= 1'b0;
      r_merge     <= 32'd0;
      r_addr      <= 10'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_rdata_vld <= w_load;
      if (w_load) begin
        r_rdata <= f_load(i_dm_dout, w_size, w_uns, i_req_addr[1:0]);
      end
      if (w_sub) begin
        r_merge <= f_merge(i_dm_dout, w_size, i_req_wdata, i_req_addr[1:0]);
        r_addr  <= i_req_addr[11:2];
      end
    end
  end

  assign o_rdata     = r_rdata;
  assign o_rdata_vld = r_rdata_vld;

`ifdef DM_ACCESS_MISALIGN_TRAP_EN
  logic r_addr_err;

  // Misalignment pulse, one cycle after the rejected request is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_accept & ~w_illegal & w_misal;
    end
  end

  assign o_addr_err = r_addr_err;
`else
  assign o_addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench for dm_access_unit: directed load/store scenarios plus a short random load/store mix.
module tb_dm_access_unit;

  localparam logic [3:0] OP_LB  = 4'h0;
  localparam logic [3:0] OP_LH  = 4'h1;
  localparam logic [3:0] OP_LW  = 4'h2;
  localparam logic [3:0] OP_LBU = 4'h4;
  localparam logic [3:0] OP_LHU = 4'h5;
  localparam logic [3:0] OP_SB  = 4'h8;
  localparam logic [3:0] OP_SH  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        rdata_vld;
  logic        addr_err;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic        dm_we;
  logic [31:0] dm_dout;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  int          we0;
  logic [31:0] exp5;

  always #5 clk = ~clk;

  dm_access_unit #(.BIG_ENDIAN(0)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op    (req_op),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rdata     (rdata),
    .o_rdata_vld (rdata_vld),
    .o_addr_err  (addr_err),
    .o_dm_addr   (dm_addr),
    .o_dm_din    (dm_din),
    .o_dm_we     (dm_we),
    .i_dm_dout   (dm_dout)
  );

  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dm_we) mem[dm_addr] <= dm_din;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Scoreboard pop: every rdata_vld pulse must match the oldest expected load and its cycle.
  always @(negedge clk) begin
    if (dm_we) we_cnt <= we_cnt + 1;
    if (rdata_vld) begin
      if (sb_q.size() == 0) begin
        check("unexpected_vld", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("rdata", rdata, e.data);
        check("latency", cyc, e.cyc);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [11:0] addr, input logic [31:0] wd,
                       input logic is_load, input logic [31:0] exp);
    int n;
    exp_t x;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
    if (is_load) begin
      x.data = exp;
      x.cyc  = cyc + 1;
      sb_q.push_back(x);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [3:0] op, input logic [11:0] a);
    logic [31:0] s;
    case (op[1:0])
      2'b00: begin
        s = w >> (8 * a[1:0]);
        m_load = op[2] ? (s & 32'h0000_00FF) : {{24{s[7]}}, s[7:0]};
      end
      2'b01: begin
        s = w >> (16 * a[1]);
        m_load = op[2] ? (s & 32'h0000_FFFF) : {{16{s[15]}}, s[15:0]};
      end
      default: m_load = w;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [3:0] op,
                                          input logic [11:0] a, input logic [31:0] d);
    logic [31:0] mask;
    logic [31:0] val;
    case (op[1:0])
      2'b00: begin
        mask = 32'h0000_00FF << (8 * a[1:0]);
        val  = (d & 32'h0000_00FF) << (8 * a[1:0]);
      end
      2'b01: begin
        mask = 32'h0000_FFFF << (16 * a[1]);
        val  = (d & 32'h0000_FFFF) << (16 * a[1]);
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        val  = d;
      end
    endcase
    m_store = (w & ~mask) | (val & mask);
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  ops [0:7];
    logic [3:0]  op;
    logic [11:0] a;
    logic [31:0] d;

    ops[0] = OP_LB; ops[1] = OP_LH; ops[2] = OP_LW; ops[3] = OP_LBU;
    ops[4] = OP_LHU; ops[5] = OP_SB; ops[6] = OP_SH; ops[7] = OP_SW;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;

    rst = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_addr = 12'h000; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_vld", {31'd0, rdata_vld}, 32'd0);
    check("rst_err", {31'd0, addr_err}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_we", {31'd0, dm_we}, 32'd0);
    rst = 1'b0;
    idle(1);

    // 1: word store and load back
    issue(OP_SW, 12'h010, 32'h1122_3344, 1'b0, 32'd0);
    issue(OP_LW, 12'h010, 32'd0, 1'b1, 32'h1122_3344);

    // 2: back-to-back byte loads, no writes
    we0 = we_cnt;
    issue(OP_LB, 12'h010, 32'd0, 1'b1, 32'h0000_0044);
    issue(OP_LB, 12'h013, 32'd0, 1'b1, 32'h0000_0011);
    idle(2);
    check("load_no_we", we_cnt - we0, 32'd0);

    // 3: byte read-modify-write
    we0 = we_cnt;
    issue(OP_SB, 12'h012, 32'h0000_0085, 1'b0, 32'd0);
    check("rmw_ready", {31'd0, req_ready}, 32'd0);
    check("rmw_we", {31'd0, dm_we}, 32'd1);
    idle(1);
    check("rmw_ready_back", {31'd0, req_ready}, 32'd1);
    check("sb_we_count", we_cnt - we0, 32'd1);
    issue(OP_LW, 12'h010, 32'd0, 1'b1, 32'h1185_3344);
    issue(OP_LB, 12'h012, 32'd0, 1'b1, 32'hFFFF_FF85);
    issue(OP_LBU, 12'h012, 32'd0, 1'b1, 32'h0000_0085);

    // 4: halfword read-modify-write
    issue(OP_SH, 12'h012, 32'h0000_BEEF, 1'b0, 32'd0);
    issue(OP_LW, 12'h010, 32'd0, 1'b1, 32'hBEEF_3344);
    issue(OP_LH, 12'h012, 32'd0, 1'b1, 32'hFFFF_BEEF);
    issue(OP_LHU, 12'h012, 32'd0, 1'b1, 32'h0000_BEEF);

    // 5: misaligned halfword store
    we0 = we_cnt;
    issue(OP_SH, 12'h011, 32'h0000_CAFE, 1'b0, 32'd0);
`ifdef DM_ACCESS_MISALIGN_TRAP_EN
    check("addr_err_pulse", {31'd0, addr_err}, 32'd1);
    idle(1);
    check("addr_err_clear", {31'd0, addr_err}, 32'd0);
    check("misal_no_we", we_cnt - we0, 32'd0);
    exp5 = 32'hBEEF_3344;
`else
    idle(1);
    check("misal_err_low", {31'd0, addr_err}, 32'd0);
    check("misal_we_count", we_cnt - we0, 32'd1);
    exp5 = 32'hBEEF_CAFE;
`endif
    issue(OP_LW, 12'h010, 32'd0, 1'b1, exp5);
    idle(2);

    // 6: reset during the write cycle of a byte store aborts it
    we0 = we_cnt;
    issue(OP_SB, 12'h010, 32'h0000_0077, 1'b0, 32'd0);
    rst = 1'b1;
    #1;
    check("abort_we", {31'd0, dm_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_rdata", rdata, 32'd0);
    idle(1);
    check("abort_we_count", we_cnt - we0, 32'd0);
    issue(OP_LW, 12'h010, 32'd0, 1'b1, exp5);

    // Random mix over four words, aligned so both builds agree
    for (int w = 0; w < 4; w++) issue(OP_SW, 12'h100 + 12'(w * 4), 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 7)];
      a  = 12'h100 + 12'($urandom_range(0, 15));
      if (op[1:0] == 2'b01) a[0] = 1'b0;
      if (op[1:0] == 2'b10) a[1:0] = 2'b00;
      d = $urandom;
      if (op[3]) begin
        ref_mem[a[11:2]] = m_store(ref_mem[a[11:2]], op, a, d);
        issue(op, a, d, 1'b0, 32'd0);
      end else begin
        issue(op, a, 32'd0, 1'b1, m_load(ref_mem[a[11:2]], op, a));
      end
    end

    idle(4);
    check("queue_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
